// File: rtl/store_write_buffer_pkg.sv
// Shared types for the data-side store write buffer.
// BLOCK_LSB is also used by the cache index/tag decoders.
package store_write_buffer_pkg;

    localparam int BLOCK_LSB = 4;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } wb_state_t;

endpackage

// File: rtl/store_write_buffer_wb_match.sv
// Parallel address compare against every buffer entry.
// LSB selects block (BLOCK_LSB) or word (0) granularity.
module wb_match
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LSB   = 0
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH-1:0][15:0] addrs,
    input  logic [15:0]            addr,
    output logic [DEPTH-1:0]       hit
);

    localparam logic [15:0] MASK = 16'hFFFF << LSB;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] & (((addrs[i] ^ addr) & MASK) == 16'h0);
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Write-through store buffer draining to the shared memory port.
// Define WB_COALESCE_EN to merge stores to an already-queued word.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WR_GAP = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [15:0]                st_addr,
    input  logic [15:0]                st_data,
    output logic                       st_ready,
    input  logic                       mem_grant,
    output logic                       mem_req,
    output logic                       mem_busy,
    output logic                       mem_enable,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_data,
    input  logic [15:0]                chk_addr,
    output logic                       chk_hazard,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    wb_entry_t [DEPTH-1:0]       entries;
    logic      [DEPTH-1:0]       ent_valid;
    logic      [DEPTH-1:0][15:0] ent_addr;
    logic      [DEPTH-1:0]       blk_hit;
    logic      [PW-1:0]          head;
    logic      [PW-1:0]          tail;
    logic      [GW-1:0]          gap_cnt;
    wb_state_t                   state;
    logic                        pop;
    logic                        push;
    logic                        alloc;
    logic                        merge;
    logic      [PW-1:0]          merge_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_addr[i]  = entries[i].addr;
        end
    end

    wb_match #(.DEPTH(DEPTH), .LSB(BLOCK_LSB)) u_blk_match (
        .valid (ent_valid),
        .addrs (ent_addr),
        .addr  (chk_addr),
        .hit   (blk_hit)
    );

`ifdef WB_COALESCE_EN
    logic [DEPTH-1:0] word_hit;
    logic [DEPTH-1:0] merge_vec;

    wb_match #(.DEPTH(DEPTH), .LSB(0)) u_word_match (
        .valid (ent_valid),
        .addrs (ent_addr),
        .addr  (st_addr),
        .hit   (word_hit)
    );

    // The head is already on the port while popping; never merge into it.
    always_comb begin
        merge_vec = word_hit;
        if (pop) merge_vec[head] = 1'b0;
        merge_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (merge_vec[i]) merge_idx = PW'(i);
        end
        merge = |merge_vec;
    end
`else
    assign merge     = 1'b0;
    assign merge_idx = '0;
`endif

    assign pop        = (state == WRITE);
    assign st_ready   = ~flush & ((count < CW'(DEPTH)) | pop | merge);
    assign push       = st_valid & st_ready;
    assign alloc      = push & ~merge;
    assign chk_hazard = |blk_hit;
    assign mem_req    = (count != '0);
    assign mem_busy   = pop;
    assign mem_enable = pop;
    assign mem_wr     = pop;
    assign mem_addr   = pop ? entries[head].addr : '0;
    assign mem_data   = pop ? entries[head].data : '0;
    assign flush_done = (count == '0) & (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (alloc) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                tail          <= tail + 1'b1;
            end
            if (push & merge) entries[merge_idx].data <= st_data;
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    // Last GAP cycle also does the IDLE grant check: one write per 1+WR_GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0 && mem_grant) state <= WRITE;
                end
                WRITE: begin
                    if (WR_GAP > 0) begin
                        state   <= GAP;
                        gap_cnt <= GW'(WR_GAP - 1);
                    end else if (count > CW'(1) && mem_grant) begin
                        state <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                    else if (count != '0 && mem_grant) state <= WRITE;
                    else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
